irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_ctrl.sv | 133 +++++++++++++
 tb/tb_irq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// config register addresses and mcause codes.
package irq_pkg;

  localparam int NUM_EXT_MAX = 16;

  localparam logic [1:0] ADDR_ENABLE    = 2'd0;
  localparam logic [1:0] ADDR_PENDING   = 2'd1;
  localparam logic [1:0] ADDR_TIMER_CMP = 2'd2;
  localparam logic [1:0] ADDR_STATUS    = 2'd3;

  localparam logic [4:0] CAUSE_TIMER    = 5'd7;
  localparam logic [4:0] CAUSE_EXT_BASE = 5'd16;

  // Writable ENABLE bits: external sources at [31:16], timer at bit 7.
  localparam logic [31:0] ENABLE_MASK = 32'hFFFF_0080;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  function automatic logic [31:0] mcause(input logic [4:0] code);
    return {1'b1, 26'd0, code};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: timer (code 7) first, then external
// sources from the lowest index (code 16) upward.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic                   timer,
  input  logic [NUM_EXT_MAX-1:0] ext,
  output logic                   valid,
  output logic [4:0]             code
);

  always_comb begin
    valid = timer | (|ext);
    code  = 5'd0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = NUM_EXT_MAX - 1; i >= 0; i--) begin
      if (ext[i]) code = CAUSE_EXT_BASE + 5'(i);
    end
    if (timer) code = CAUSE_TIMER;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected external sources, optional timer source
// (define IRQ_TIMER_EN), ENABLE/PENDING/TIMER_CMP/STATUS config registers and
// an IDLE/REQ/SERVICE trap-request FSM. STATUS[9:8] exposes the FSM state.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_EXT       = 16,
  parameter logic [7:0]  TIMER_RST_CMP = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               global_ie,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               trap_req,
  output logic [31:0]        trap_cause,
  input  logic               trap_ack,
  input  logic               mret,
  output logic               irq_busy,
  output logic               timer_irq
);

  irq_state_e         state_q, state_d;
  logic [NUM_EXT-1:0] ext_prev_q;
  logic [31:0]        enable_q, pending_q, pending_set, pending_clr, elig;
  logic               trap_req_q;
  logic [31:0]        cause_q;
  logic               win_valid, ack_take, latched_elig;
  logic [4:0]         win_code;
  logic [7:0]         timer_cmp_rd;

  wire wr_enable  = cfg_wr && (cfg_addr == ADDR_ENABLE);
  wire wr_pending = cfg_wr && (cfg_addr == ADDR_PENDING);

`ifdef IRQ_TIMER_EN
  logic [7:0] timer_cnt_q, timer_cmp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_cnt_q <= 8'd0;
      timer_cmp_q <= TIMER_RST_CMP;
    end else begin
      timer_cnt_q <= timer_cnt_q + 8'd1;
      if (cfg_wr && (cfg_addr == ADDR_TIMER_CMP)) timer_cmp_q <= cfg_wdata[7:0];
    end
  end

  assign timer_irq    = (timer_cnt_q == timer_cmp_q);
  assign timer_cmp_rd = timer_cmp_q;
`else
  assign timer_irq    = 1'b0;
  assign timer_cmp_rd = 8'h00;
`endif

  assign elig         = pending_q & enable_q;
  assign latched_elig = elig[cause_q[4:0]];

  irq_prio_enc u_prio (
    .timer (elig[7]),
    .ext   (elig[31:16]),
    .valid (win_valid),
    .code  (win_code)
  );

  // Set and clear can both hit a bit in one cycle; set is OR-ed in last so it wins.
  always_comb begin
    pending_set    = 32'd0;
    pending_set[7] = timer_irq;
    for (int i = 0; i < NUM_EXT; i++) begin
      pending_set[16 + i] = ext_irq[i] & ~ext_prev_q[i];
    end
    pending_clr = wr_pending ? cfg_wdata : 32'd0;
    if (ack_take) pending_clr = pending_clr | (32'd1 << cause_q[4:0]);
  end

  // trap_req/trap_ack: trap_req rises with trap_cause valid and both hold until
  // trap_ack is sampled high in REQ; losing global_ie or the latched source's
  // eligibility first withdraws the request. trap_ack/mret elsewhere are ignored.
  always_comb begin
    state_d  = state_q;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE:    if (global_ie && win_valid) state_d = ST_REQ;
      ST_REQ: begin
        if (!global_ie || !latched_elig) begin
          state_d = ST_IDLE;
        end else if (trap_ack) begin
          state_d  = ST_SERVICE;
          ack_take = 1'b1;
        end
      end
      ST_SERVICE: if (mret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ext_prev_q <= '0;
      enable_q   <= 32'd0;
      pending_q  <= 32'd0;
      trap_req_q <= 1'b0;
      cause_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      ext_prev_q <= ext_irq;
      if (wr_enable) enable_q <= cfg_wdata & ENABLE_MASK;
      pending_q  <= (pending_q & ~pending_clr) | pending_set;
      trap_req_q <= (state_d == ST_REQ);
      if (state_q == ST_IDLE && state_d == ST_REQ) cause_q <= mcause(win_code);
    end
  end

  always_comb begin
    cfg_rdata = 32'd0;
    case (cfg_addr)
      ADDR_ENABLE:    cfg_rdata = enable_q;
      ADDR_PENDING:   cfg_rdata = pending_q;
      ADDR_TIMER_CMP: cfg_rdata = {24'd0, timer_cmp_rd};
      ADDR_STATUS:    cfg_rdata = {22'd0, state_q, 3'd0, cause_q[4:0]};
      default:        cfg_rdata = 32'd0;
    endcase
  end

  assign trap_req   = trap_req_q;
  assign trap_cause = cause_q;
  assign irq_busy   = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, trap handshake, priority, masking,
// W1C/set collision, register bits, timer (when built with it), async reset.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clk, reset;
  logic [15:0] ext_irq;
  logic        global_ie, cfg_wr, trap_ack, mret;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata, trap_cause;
  logic        trap_req, irq_busy, timer_irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .global_ie(global_ie),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_ack(trap_ack), .mret(mret), .irq_busy(irq_busy), .timer_irq(timer_irq)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr = 1'b0; cfg_wdata = 32'd0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic pulse_ack();
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; step(); mret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ext_irq = '0; global_ie = 1'b0; cfg_wr = 1'b0;
    cfg_addr = 2'd0; cfg_wdata = 32'd0; trap_ack = 1'b0; mret = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL rst_trap_req: got %b want 0", trap_req); end
    checks++; if (trap_cause !== 32'd0) begin errors++; $display("FAIL rst_cause: got %h want 0", trap_cause); end
    checks++; if (irq_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", irq_busy); end
    cfg_read(ADDR_ENABLE, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_enable: got %h want 0", rd); end
    cfg_read(ADDR_PENDING, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_pending: got %h want 0", rd); end
    cfg_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_status: got %h want 0", rd); end
    cfg_read(ADDR_TIMER_CMP, rd);
`ifdef IRQ_TIMER_EN
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL rst_timer_cmp: got %h want 000000ff", rd); end
`else
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_timer_cmp: got %h want 0", rd); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL rst_timer_irq: got %b want 0", timer_irq); end
`endif
  endtask

  task automatic test_basic();
    cfg_write(ADDR_ENABLE, 32'h0001_0000);
    global_ie = 1'b1;
    ext_irq[0] = 1'b1;
    step();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b want 0", trap_req); end
    cfg_read(ADDR_PENDING, rd);
    checks++; if ((rd & 32'hFFFF_0000) !== 32'h0001_0000) begin errors++; $display("FAIL basic_pending_set: got %h want 00010000", rd); end
    step();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", trap_req); end
    checks++; if (trap_cause !== 32'h8000_0010) begin errors++; $display("FAIL basic_cause: got %h want 80000010", trap_cause); end
    cfg_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'h0000_0110) begin errors++; $display("FAIL basic_status_req: got %h want 00000110", rd); end
    step();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0010) begin errors++; $display("FAIL basic_hold: got %b/%h want 1/80000010", trap_req, trap_cause); end
    pulse_ack();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL basic_ack_req: got %b want 0", trap_req); end
    checks++; if (irq_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", irq_busy); end
    cfg_read(ADDR_PENDING, rd);
    checks++; if ((rd & 32'hFFFF_0000) !== 32'd0) begin errors++; $display("FAIL basic_pending_clr: got %h want 0", rd); end
    cfg_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'h0000_0210) begin errors++; $display("FAIL basic_status_svc: got %h want 00000210", rd); end
  endtask

  task automatic test_service_block();
    cfg_write(ADDR_ENABLE, 32'h0005_0000);
    ext_irq[2] = 1'b1;
    repeat (4) step();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL svc_no_req: got %b want 0", trap_req); end
    cfg_read(ADDR_PENDING, rd);
    checks++; if ((rd & 32'hFFFF_0000) !== 32'h0004_0000) begin errors++; $display("FAIL svc_pending: got %h want 00040000", rd); end
    pulse_mret();
    checks++; if (trap_req !== 1'b0 || irq_busy !== 1'b0) begin errors++; $display("FAIL svc_mret_idle: got req=%b busy=%b want 0/0", trap_req, irq_busy); end
    step();
    checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL svc_req_after_mret: got %b want 1", trap_req); end
    checks++; if (trap_cause !== 32'h8000_0012) begin errors++; $display("FAIL svc_cause: got %h want 80000012", trap_cause); end
    pulse_ack();
    pulse_mret();
    ext_irq = '0;
    step();
  endtask

  task automatic test_ie_drop();
    cfg_write(ADDR_ENABLE, 32'h0010_0000);
    ext_irq[4] = 1'b1;
    step();
    step();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0014) begin errors++; $display("FAIL ie_req: got %b/%h want 1/80000014", trap_req, trap_cause); end
    global_ie = 1'b0;
    step();
    checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL ie_drop_req: got %b want 0", trap_req); end
    cfg_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'h0000_0014) begin errors++; $display("FAIL ie_drop_status: got %h want 00000014", rd); end
    cfg_read(ADDR_PENDING, rd);
    checks++; if ((rd & 32'hFFFF_0000) !== 32'h0010_0000) begin errors++; $display("FAIL ie_drop_pending: got %h want 00100000", rd); end
    global_ie = 1'b1;
    step();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0014) begin errors++; $display("FAIL ie_rereq: got %b/%h want 1/80000014", trap_req, trap_cause); end
    pulse_ack();
    pulse_mret();
    ext_irq = '0;
    step();
  endtask

  task automatic test_priority();
    cfg_write(ADDR_ENABLE, 32'h000A_0000);
    ext_irq[1] = 1'b1;
    ext_irq[3] = 1'b1;
    step();
    step();
    checks++; if (trap_cause !== 32'h8000_0011) begin errors++; $display("FAIL prio_first: got %h want 80000011", trap_cause); end
    pulse_mret();
    checks++; if (trap_req !== 1'b1 || irq_busy !== 1'b0) begin errors++; $display("FAIL prio_mret_in_req: got req=%b busy=%b want 1/0", trap_req, irq_busy); end
    pulse_ack();
    pulse_mret();
    step();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0013) begin errors++; $display("FAIL prio_second: got %b/%h want 1/80000013", trap_req, trap_cause); end
    pulse_ack();
    pulse_mret();
    pulse_ack();
    cfg_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'h0000_0013) begin errors++; $display("FAIL prio_ack_in_idle: got %h want 00000013", rd); end
    ext_irq = '0;
    step();
  endtask

  task automatic test_w1c_collision();
    global_ie = 1'b0;
    ext_irq[1] = 1'b1;
    step();
    cfg_read(ADDR_PENDING, rd);
    checks++; if ((rd & 32'hFFFF_0000) !== 32'h0002_0000) begin errors++; $display("FAIL w1c_pre: got %h want 00020000", rd); end
    ext_irq[1] = 1'b0;
    step();
    ext_irq[1] = 1'b1;
    cfg_write(ADDR_PENDING, 32'h0002_0000);
    cfg_read(ADDR_PENDING, rd);
    checks++; if ((rd & 32'hFFFF_0000) !== 32'h0002_0000) begin errors++; $display("FAIL w1c_set_wins: got %h want 00020000", rd); end
    cfg_write(ADDR_PENDING, 32'h0002_0000);
    cfg_read(ADDR_PENDING, rd);
    checks++; if ((rd & 32'hFFFF_0000) !== 32'd0) begin errors++; $display("FAIL w1c_clear: got %h want 0", rd); end
    ext_irq = '0;
    step();
  endtask

  task automatic test_regs();
    cfg_write(ADDR_ENABLE, 32'hFFFF_FFFF);
    cfg_read(ADDR_ENABLE, rd);
    checks++; if (rd !== 32'hFFFF_0080) begin errors++; $display("FAIL regs_enable_bits: got %h want ffff0080", rd); end
    cfg_write(ADDR_STATUS, 32'hFFFF_FFFF);
    cfg_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'h0000_0013) begin errors++; $display("FAIL regs_status_ro: got %h want 00000013", rd); end
    cfg_write(ADDR_TIMER_CMP, 32'h0000_0012);
    cfg_read(ADDR_TIMER_CMP, rd);
`ifdef IRQ_TIMER_EN
    checks++; if (rd !== 32'h0000_0012) begin errors++; $display("FAIL regs_timer_cmp: got %h want 00000012", rd); end
    cfg_write(ADDR_TIMER_CMP, 32'h0000_00FF);
`else
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL regs_timer_cmp: got %h want 0", rd); end
    repeat (5) step();
    cfg_read(ADDR_PENDING, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL regs_no_timer_pend: got %h want 0", rd); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL regs_timer_irq: got %b want 0", timer_irq); end
`endif
    cfg_write(ADDR_ENABLE, 32'd0);
  endtask

`ifdef IRQ_TIMER_EN
  task automatic test_timer();
    bit seen_pulse;
    bit found;
    seen_pulse = 1'b0;
    found = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    global_ie = 1'b0;
    cfg_write(ADDR_ENABLE, 32'h0008_0080);
    ext_irq[3] = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (timer_irq === 1'b1) seen_pulse = 1'b1;
      cfg_read(ADDR_PENDING, rd);
      if (rd[7] === 1'b1) found = 1'b1;
    end
    checks++; if (!found || rd !== 32'h0008_0080) begin errors++; $display("FAIL timer_pending: got %h want 00080080 (found=%0b)", rd, found); end
    checks++; if (seen_pulse !== 1'b1) begin errors++; $display("FAIL timer_irq_pulse: got %b want 1", seen_pulse); end
    global_ie = 1'b1;
    step();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0007) begin errors++; $display("FAIL timer_cause: got %b/%h want 1/80000007", trap_req, trap_cause); end
    pulse_ack();
    pulse_mret();
    step();
    checks++; if (trap_req !== 1'b1 || trap_cause !== 32'h8000_0013) begin errors++; $display("FAIL timer_then_ext: got %b/%h want 1/80000013", trap_req, trap_cause); end
    pulse_ack();
    pulse_mret();
    ext_irq = '0;
    cfg_write(ADDR_ENABLE, 32'd0);
  endtask
`endif

  task automatic test_async_reset();
    global_ie = 1'b1;
    cfg_write(ADDR_ENABLE, 32'h0020_0000);
    ext_irq[5] = 1'b1;
    step();
    step();
    pulse_ack();
    checks++; if (irq_busy !== 1'b1) begin errors++; $display("FAIL areset_busy_before: got %b want 1", irq_busy); end
    #3;
    trap_ack = 1'b1; mret = 1'b1; reset = 1'b1;
    #1;
    checks++; if (trap_req !== 1'b0 || irq_busy !== 1'b0 || trap_cause !== 32'd0) begin errors++; $display("FAIL areset_immediate: got req=%b busy=%b cause=%h want 0/0/0", trap_req, irq_busy, trap_cause); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL areset_timer_irq: got %b want 0", timer_irq); end
    ext_irq = '0;
    step();
    checks++; if (irq_busy !== 1'b0 || trap_req !== 1'b0) begin errors++; $display("FAIL areset_over_ack_mret: got busy=%b req=%b want 0/0", irq_busy, trap_req); end
    reset = 1'b0; trap_ack = 1'b0; mret = 1'b0;
    cfg_read(ADDR_ENABLE, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL areset_enable: got %h want 0", rd); end
    cfg_read(ADDR_PENDING, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL areset_pending: got %h want 0", rd); end
    cfg_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL areset_status: got %h want 0", rd); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_service_block();
    test_ie_drop();
    test_priority();
    test_w1c_collision();
    test_regs();
`ifdef IRQ_TIMER_EN
    test_timer();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
